// File: rtl/mult_sched_pkg.sv
// Shared definitions for the multiplier scheduler: FSM encoding,
// operand width, default watchdog limit and a small index helper.
package mult_sched_pkg;

  localparam int DATA_W             = 32;
  localparam int TIMEOUT_CYCLES_DEF = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Next requester index after idx, wrapping at n.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin picker: grants the first set request bit at
// or after ptr, wrapping modulo NUM_REQ. Priority state lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_req
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Walk the requesters starting at ptr and take the first active one.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one iterative 32x32 multiplier among
// NUM_REQ requesters. One request in flight at a time; the result is
// returned tagged with the owning requester index.
// Optional watchdog: define MULT_SCHED_TIMEOUT_EN to abort a BUSY phase
// after TIMEOUT_CYCLES cycles without a ready and raise timeout_err.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_opA,
  input  logic [NUM_REQ*DATA_W-1:0] req_opB,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      resp_exception,
`ifdef MULT_SCHED_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output logic                      busy,
  output logic                      mult_start,
  output logic [DATA_W-1:0]         mult_opA,
  output logic [DATA_W-1:0]         mult_opB,
  input  logic [DATA_W-1:0]         mult_result,
  input  logic                      mult_exception,
  input  logic                      mult_rdy
);

  // Elaboration-time sanity check of the configuration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mult_sched: unsupported NUM_REQ/ID_W/TIMEOUT_CYCLES combination");
  end

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic                start_q, start_d;
  logic                arm_q, arm_d;     // set after the first BUSY cycle
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rres_q, rres_d;
  logic                rexc_q, rexc_d;

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                terr_q, terr_d;
`endif

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic [DATA_W-1:0]   opa_arr [NUM_REQ];
  logic [DATA_W-1:0]   opb_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign opa_arr[i] = req_opA[i*DATA_W +: DATA_W];
    assign opb_arr[i] = req_opB[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  // Grants only in IDLE; masked during reset so every output reads 0 then.
  assign req_ready      = arb_gnt & {NUM_REQ{(state_q == IDLE) && reset_n}};
  assign busy           = (state_q != IDLE);
  assign mult_start     = start_q;
  assign mult_opA       = opa_q;
  assign mult_opB       = opb_q;
  assign resp_valid     = rvalid_q;
  assign resp_id        = gid_q;
  assign resp_result    = rres_q;
  assign resp_exception = rexc_q;
`ifdef MULT_SCHED_TIMEOUT_EN
  assign timeout_err    = terr_q;
`endif

  // Next-state and registered-output computation for the scheduler FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    start_d  = 1'b0;
    arm_d    = arm_q;
    rvalid_d = rvalid_q;
    rres_d   = rres_q;
    rexc_d   = rexc_q;
`ifdef MULT_SCHED_TIMEOUT_EN
    cnt_d    = cnt_q;
    terr_d   = terr_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gid_d   = arb_idx;
          opa_d   = opa_arr[arb_idx];
          opb_d   = opb_arr[arb_idx];
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        arm_d   = 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = BUSY;
      end
      BUSY: begin
        // A ready seen in the first BUSY cycle may be left over from the
        // previous operation, so it is only honoured once armed.
        arm_d = 1'b1;
        if (arm_q && mult_rdy) begin
          rres_d   = mult_result;
          rexc_d   = mult_exception;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
`ifdef MULT_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rres_d   = '0;
          rexc_d   = 1'b1;
          rvalid_d = 1'b1;
          terr_d   = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          ptr_d    = ID_W'(next_idx(int'(gid_q), NUM_REQ));
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and all registered outputs; reset aborts any operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gid_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      start_q  <= 1'b0;
      arm_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rres_q   <= '0;
      rexc_q   <= 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
      cnt_q    <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      start_q  <= start_d;
      arm_q    <= arm_d;
      rvalid_q <= rvalid_d;
      rres_q   <= rres_d;
      rexc_q   <= rexc_d;
`ifdef MULT_SCHED_TIMEOUT_EN
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
`endif
    end
  end

endmodule
